// File: rtl/abl_pkg.sv
// Shared definitions for the address-low block: op field layout, base and
// addend select codes, and the interrupt/reset vector low bytes.
// Vector constants are only referenced when ABL_VECTOR_EN is defined.
package abl_pkg;

  localparam int unsigned DW          = 8;  // data/address byte width
  localparam int unsigned SW          = DW + 1; // adder width including carry
  localparam int unsigned OPW         = 6;
  localparam int unsigned OP_BASE_LSB = 0;
  localparam int unsigned OP_BASE_W   = 3;
  localparam int unsigned OP_SEL_LSB  = 3;
  localparam int unsigned OP_SEL_W    = 2;
  localparam int unsigned OP_CI_BIT   = 5;

  // Base operand select, op[2:0]
  typedef enum logic [OP_BASE_W-1:0] {
    BASE_ABL     = 3'b000,
    BASE_PCL     = 3'b001,
    BASE_DB      = 3'b010,
    BASE_TMP     = 3'b011,
    BASE_SP      = 3'b100,
    BASE_VEC     = 3'b101,
    BASE_ZERO    = 3'b110,
    BASE_ABL_ALT = 3'b111
  } base_e;

  // Addend select, op[4:3]; doubles as the vector select when base is BASE_VEC
  typedef enum logic [OP_SEL_W-1:0] {
    ADD_ZERO     = 2'b00,
    ADD_REG      = 2'b01,
    ADD_ZERO_ALT = 2'b10,
    ADD_ONES     = 2'b11
  } addend_e;

  localparam logic [DW-1:0] VEC_NMI = 8'hFA;
  localparam logic [DW-1:0] VEC_RST = 8'hFC;
  localparam logic [DW-1:0] VEC_IRQ = 8'hFE;

endpackage

// File: rtl/abl_base_mux.sv
// Base operand selection for the address-low adder, including the vector
// low-byte decode (only built when ABL_VECTOR_EN is defined; otherwise the
// vector base reads as zero).
// Ports: abl/pcl/db/tmp/sp candidate bases, base_sel (op[2:0]),
//        vec_sel (op[4:3]), base (selected 8-bit operand, combinational).
module abl_base_mux
  import abl_pkg::*;
(
  input  logic [DW-1:0]       abl,
  input  logic [DW-1:0]       pcl,
  input  logic [DW-1:0]       db,
  input  logic [DW-1:0]       tmp,
  input  logic [DW-1:0]       sp,
  input  base_e               base_sel,
  input  logic [OP_SEL_W-1:0] vec_sel,
  output logic [DW-1:0]       base
);

  logic [DW-1:0] vec_byte;

`ifdef ABL_VECTOR_EN
  // Vector low byte: NMI, RESET, IRQ/BRK, and the spare code aliases IRQ
  always_comb begin
    vec_byte = VEC_IRQ;
    case (vec_sel)
      2'b00:   vec_byte = VEC_NMI;
      2'b01:   vec_byte = VEC_RST;
      default: vec_byte = VEC_IRQ;
    endcase
  end
`else
  logic unused_vec_sel;
  assign unused_vec_sel = ^vec_sel;
  assign vec_byte       = '0;
`endif

  always_comb begin
    base = '0;
    case (base_sel)
      BASE_ABL, BASE_ABL_ALT: base = abl;
      BASE_PCL:               base = pcl;
      BASE_DB:                base = db;
      BASE_TMP:               base = tmp;
      BASE_SP:                base = sp;
      BASE_VEC:               base = vec_byte;
      default:                base = '0;
    endcase
  end

endmodule

// File: rtl/abl.sv
// Address-low block: 8-bit adder forming the next address-low byte (ADL) and
// its carry (CO) to the address-high block, plus the ABL, PCL and TMP
// registers. Optional vector-constant base enabled by macro ABL_VECTOR_EN.
// Ports: clk, RST (sync active-high), DB (data bus), REG (X/Y index),
//        SP (stack pointer), op (base/addend/carry-in), ld_tmp, ld_pc,
//        inc_pc; ADL/CO combinational, ABL/PCL registered.
module abl
  import abl_pkg::*;
(
  input  logic           clk,
  input  logic           RST,
  input  logic [DW-1:0]  DB,
  input  logic [DW-1:0]  REG,
  input  logic [DW-1:0]  SP,
  input  logic [OPW-1:0] op,
  input  logic           ld_tmp,
  input  logic           ld_pc,
  input  logic           inc_pc,
  output logic [DW-1:0]  ADL,
  output logic           CO,
  output logic [DW-1:0]  ABL,
  output logic [DW-1:0]  PCL
);

  logic [DW-1:0]       abl_q;
  logic [DW-1:0]       pcl_q;
  logic [DW-1:0]       tmp_q;
  logic [DW-1:0]       base;
  logic [DW-1:0]       addend;
  logic [SW-1:0]       sum;
  base_e               base_sel;
  logic [OP_SEL_W-1:0] sel;
  logic                ci;

  assign base_sel = base_e'(op[OP_BASE_LSB +: OP_BASE_W]);
  assign sel      = op[OP_SEL_LSB +: OP_SEL_W];
  assign ci       = op[OP_CI_BIT];

  abl_base_mux u_base_mux (
    .abl      (abl_q),
    .pcl      (pcl_q),
    .db       (DB),
    .tmp      (tmp_q),
    .sp       (SP),
    .base_sel (base_sel),
    .vec_sel  (sel),
    .base     (base)
  );

  // Addend; the vector base always adds zero since op[4:3] picks the vector
  always_comb begin
    addend = '0;
    if (base_sel != BASE_VEC) begin
      case (addend_e'(sel))
        ADD_REG:  addend = REG;
        ADD_ONES: addend = '1;
        default:  addend = '0;
      endcase
    end
  end

  // 9-bit sum: ADL is the low byte, CO the carry (CO=0 with FF addend = borrow)
  assign sum = SW'(base) + SW'(addend) + SW'(ci);
  assign ADL = sum[DW-1:0];
  assign CO  = sum[DW];

  // ABL follows ADL every cycle; TMP and PCL load on demand, reset wins
  always_ff @(posedge clk) begin
    if (RST) begin
      abl_q <= '0;
      pcl_q <= '0;
      tmp_q <= '0;
    end else begin
      abl_q <= sum[DW-1:0];
      if (ld_tmp) tmp_q <= DB;
      if (ld_pc)  pcl_q <= abl_q + DW'(inc_pc);
    end
  end

  assign ABL = abl_q;
  assign PCL = pcl_q;

endmodule

// File: tb/tb_abl.sv
// Directed self-checking bench for abl with a scoreboard of expected values.
module tb_abl;

  logic       clk;
  logic       RST;
  logic [7:0] DB;
  logic [7:0] REG;
  logic [7:0] SP;
  logic [5:0] op;
  logic       ld_tmp;
  logic       ld_pc;
  logic       inc_pc;
  logic [7:0] ADL;
  logic       CO;
  logic [7:0] ABL;
  logic [7:0] PCL;

  abl dut (
    .clk    (clk),
    .RST    (RST),
    .DB     (DB),
    .REG    (REG),
    .SP     (SP),
    .op     (op),
    .ld_tmp (ld_tmp),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .ADL    (ADL),
    .CO     (CO),
    .ABL    (ABL),
    .PCL    (PCL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_ADL = 0;
  localparam int K_CO  = 1;
  localparam int K_ABL = 2;
  localparam int K_PCL = 3;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_reg[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [7:0] observe(int kind);
    case (kind)
      K_ADL:   return ADL;
      K_CO:    return {7'b0, CO};
      K_ABL:   return ABL;
      default: return PCL;
    endcase
  endfunction

  task automatic exp_comb(string tag, int kind, logic [7:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = v;
    q_comb.push_back(e);
  endtask

  task automatic exp_reg(string tag, int kind, logic [7:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = v;
    q_reg.push_back(e);
  endtask

  task automatic compare(exp_t e);
    logic [7:0] o;
    o = observe(e.kind);
    vectors++;
    assert (o === e.val) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", e.tag, o, e.val);
    end
  endtask

  // Settle combinational paths, then pop and check combinational expectations
  task automatic check_comb();
    exp_t e;
    #1;
    while (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      compare(e);
    end
  endtask

  // Advance one rising edge, then pop and check registered expectations
  task automatic clock_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    while (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      compare(e);
    end
  endtask

  initial begin
    RST = 1'b1; DB = 8'h00; REG = 8'h00; SP = 8'h00; op = 6'b000000;
    ld_tmp = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;
    exp_reg("rst_abl", K_ABL, 8'h00);
    exp_reg("rst_pcl", K_PCL, 8'h00);
    clock_and_check();

    // Post-reset ABL+0
    RST = 1'b0; op = 6'b000000;
    exp_comb("post_rst_adl", K_ADL, 8'h00);
    exp_comb("post_rst_co",  K_CO,  8'h00);
    check_comb();
    // TMP cleared by reset
    op = 6'b000011;
    exp_comb("tmp_rst_adl", K_ADL, 8'h00);
    check_comb();
    clock_and_check();

    // DB + REG with carry out
    DB = 8'hF0; REG = 8'h20; op = 6'b001010;
    exp_comb("db_reg_adl", K_ADL, 8'h10);
    exp_comb("db_reg_co",  K_CO,  8'h01);
    check_comb();
    exp_reg("db_reg_abl", K_ABL, 8'h10);
    clock_and_check();

    // Clear ABL via zero base
    op = 6'b000110;
    exp_reg("zero_abl", K_ABL, 8'h00);
    clock_and_check();

    // ABL + FF without/with carry-in
    op = 6'b111000;
    exp_comb("dec_ci1_adl", K_ADL, 8'h00);
    exp_comb("dec_ci1_co",  K_CO,  8'h01);
    check_comb();
    op = 6'b011000;
    exp_comb("dec_ci0_adl", K_ADL, 8'hFF);
    exp_comb("dec_ci0_co",  K_CO,  8'h00);
    check_comb();
    exp_reg("dec_abl", K_ABL, 8'hFF);
    clock_and_check();

    // Hold keeps ABL
    op = 6'b000111;
    exp_reg("hold_abl", K_ABL, 8'hFF);
    clock_and_check();

    // SP base, with REG addend and with the alias zero addend
    SP = 8'h42; REG = 8'h01; op = 6'b001100;
    exp_comb("sp_reg_adl", K_ADL, 8'h43);
    exp_comb("sp_reg_co",  K_CO,  8'h00);
    check_comb();
    op = 6'b010100;
    exp_comb("sp_zero_adl", K_ADL, 8'h42);
    check_comb();

    // Load ABL=7F from DB, then PCL = ABL + 1
    DB = 8'h7F; op = 6'b000010;
    exp_reg("abl_7f", K_ABL, 8'h7F);
    clock_and_check();
    ld_pc = 1'b1; inc_pc = 1'b1; op = 6'b000111;
    exp_reg("pcl_80", K_PCL, 8'h80);
    clock_and_check();
    ld_pc = 1'b0; inc_pc = 1'b0; op = 6'b000001;
    exp_comb("pcl_base_adl", K_ADL, 8'h80);
    check_comb();

    // ABL=FF, wrap with carry-in, and PCL increment wrap
    DB = 8'hFF; op = 6'b000010;
    exp_reg("abl_ff", K_ABL, 8'hFF);
    clock_and_check();
    ld_pc = 1'b1; inc_pc = 1'b1; op = 6'b100000;
    exp_comb("wrap_adl", K_ADL, 8'h00);
    exp_comb("wrap_co",  K_CO,  8'h01);
    check_comb();
    exp_reg("pcl_wrap", K_PCL, 8'h00);
    exp_reg("wrap_abl", K_ABL, 8'h00);
    clock_and_check();
    ld_pc = 1'b1; inc_pc = 1'b0; op = 6'b000111;
    exp_reg("pcl_noinc", K_PCL, 8'h00);
    clock_and_check();
    ld_pc = 1'b0;

    // TMP load and same-cycle use sees the old TMP
    ld_tmp = 1'b1; DB = 8'hA5;
    clock_and_check();
    DB = 8'h3C; op = 6'b000011;
    exp_comb("tmp_old_adl", K_ADL, 8'hA5);
    check_comb();
    clock_and_check();
    ld_tmp = 1'b0; DB = 8'h00;
    exp_comb("tmp_new_adl", K_ADL, 8'h3C);
    check_comb();

    // Vector base
    op = 6'b001101;
`ifdef ABL_VECTOR_EN
    exp_comb("vec_rst_adl", K_ADL, 8'hFC);
`else
    exp_comb("vec_rst_adl", K_ADL, 8'h00);
`endif
    exp_comb("vec_rst_co", K_CO, 8'h00);
    check_comb();
    op = 6'b101101;
`ifdef ABL_VECTOR_EN
    exp_comb("vec_rst_ci_adl", K_ADL, 8'hFD);
`else
    exp_comb("vec_rst_ci_adl", K_ADL, 8'h01);
`endif
    check_comb();
    op = 6'b000101;
`ifdef ABL_VECTOR_EN
    exp_comb("vec_nmi_adl", K_ADL, 8'hFA);
`else
    exp_comb("vec_nmi_adl", K_ADL, 8'h00);
`endif
    check_comb();
    op = 6'b010101;
`ifdef ABL_VECTOR_EN
    exp_comb("vec_irq_adl", K_ADL, 8'hFE);
`else
    exp_comb("vec_irq_adl", K_ADL, 8'h00);
`endif
    check_comb();

    // Set PCL nonzero, then mid-sequence reset overrides all loads
    DB = 8'h10; op = 6'b000010;
    clock_and_check();
    ld_pc = 1'b1; inc_pc = 1'b0; op = 6'b000111;
    exp_reg("pcl_pre_rst", K_PCL, 8'h10);
    clock_and_check();
    RST = 1'b1; ld_tmp = 1'b1; ld_pc = 1'b1; inc_pc = 1'b1;
    DB = 8'h77; op = 6'b000010;
    exp_comb("rst_comb_adl", K_ADL, 8'h77);
    check_comb();
    exp_reg("mid_rst_abl", K_ABL, 8'h00);
    exp_reg("mid_rst_pcl", K_PCL, 8'h00);
    clock_and_check();
    RST = 1'b0; ld_tmp = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0; op = 6'b000011;
    exp_comb("mid_rst_tmp", K_ADL, 8'h00);
    check_comb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
